tdc_readout: RTL
================

TDC_READOUT -- requirements
Module: tdc_readout

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered events (power of two, 2..16).
REQ-002 SHALL have parameter CHANNEL_ID, default 0, 4-bit channel tag inserted in each output word.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_hasEvent  input  1  TDC event-ready flag.
REQ-006 SHALL have port i_pulseWidth  input  32  TDC time-over-threshold.
REQ-007 SHALL have port i_timestamp  input  32  TDC timestamp.
REQ-008 SHALL have port o_clear  output  1  one-cycle acknowledge pulse to the TDC i_clear.
REQ-009 SHALL have port o_valid  output  1  output word available.
REQ-010 SHALL have port i_ready  input  1  consumer accepts word when high with o_valid.
REQ-011 SHALL have port o_data  output  68  {CHANNEL_ID[3:0], pulseWidth[31:0], timestamp[31:0]}, MSB first.
REQ-012 SHALL have port o_full  output  1  FIFO holds FIFO_DEPTH words.
REQ-013 SHALL have port o_overflow  output  1  sticky: an event was dropped since reset.

Function
REQ-014 SHALL implement FSM IDLE, ACK, WAIT_LOW.
REQ-015 IDLE: i_hasEvent=1 at edge N SHALL latch i_pulseWidth/i_timestamp, go ACK, assert o_clear during cycle N+1.
REQ-016 ACK: SHALL write latched word to FIFO at edge N+1 (if not full) and go WAIT_LOW; o_clear high exactly one cycle.
REQ-017 WAIT_LOW: SHALL return to IDLE on the first edge where i_hasEvent=0; no capture while in WAIT_LOW.
REQ-018 Minimum event spacing: capture at N, next capture no earlier than N+3.
REQ-019 Write-to-o_valid latency: word written at edge N+1 SHALL raise o_valid in cycle N+2 if FIFO was empty.
REQ-020 o_data SHALL hold head-of-FIFO word, stable while o_valid=1 and i_ready=0.
REQ-021 Pop SHALL occur on edge where o_valid=1 and i_ready=1; o_valid/o_data update next cycle.
REQ-022 Full: write attempted with FIFO full and no simultaneous pop SHALL drop the word, set o_overflow; o_clear still issued.
REQ-023 Full with simultaneous pop and write: both SHALL succeed; count unchanged; no overflow.
REQ-024 Empty: i_ready with o_valid=0 SHALL have no effect.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; occupancy counter width clog2(FIFO_DEPTH)+1.
REQ-026 Words SHALL leave in capture order.

Reset
REQ-027 reset=1 at an edge SHALL force FSM IDLE, FIFO empty, o_valid=0, o_clear=0, o_full=0, o_overflow=0; o_data value is don't-care while o_valid=0.
REQ-028 Reset mid-operation (ACK or WAIT_LOW) SHALL discard the pending word; no o_clear issued after reset.
REQ-029 First capture after reset SHALL be possible on the first edge with reset=0 and i_hasEvent=1.

Configuration
REQ-030 Macro TDC_READOUT_DROP_COUNT_EN SHALL, when defined, add output o_dropCount (16 bit) counting dropped events, saturating at 16'hFFFF, cleared by reset.
REQ-031 Without TDC_READOUT_DROP_COUNT_EN, port o_dropCount SHALL not exist; all other behaviour identical.

Structure
REQ-032 Shared package tdc_pkg SHALL hold: typedef tdc_event_t (channel 4, tot 32, ts 32), FSM state enum, constant TDC_WORD_W = 68.
REQ-033 FIFO storage and pointers SHALL be one sub-module tdc_event_fifo (synchronous, single clock, show-ahead); FSM in tdc_readout.

Verification
REQ-034 Single event: TOT=32'h10, TS=32'h100, i_ready=1 -> o_clear one cycle after i_hasEvent, o_valid two cycles after, o_data={CHANNEL_ID,32'h10,32'h100}.
REQ-035 Fill: 5 events, i_ready=0, FIFO_DEPTH=4 -> o_full=1 after 4th, 5th dropped, o_overflow=1, o_dropCount=1 (macro on), 5 o_clear pulses.
REQ-036 Drain order: then i_ready=1 -> 4 words out in capture order over 4 consecutive cycles, o_valid=0 after.
REQ-037 Full with simultaneous pop+write: full FIFO, i_ready=1 at write edge -> no overflow, count stays 4.
REQ-038 Reset in WAIT_LOW with i_hasEvent held -> FIFO empty, o_clear=0; after release, held i_hasEvent captured once.
REQ-039 Backpressure: i_ready=0 for 10 cycles with o_valid=1 -> o_data unchanged for all 10 cycles.

Source files
------------

// File: rtl/tdc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdc_pkg
// Description : Shared types and constants for the TDC readout block:
//               event word layout, readout FSM state encoding, word width.
// Revision    : 1.0  initial release
// ============================================================================
package tdc_pkg;

    // Width of one output word: channel(4) + time-over-threshold(32) + timestamp(32)
    localparam int TDC_WORD_W = 68;

    // Packed so that the channel tag lands in the MSBs of the output word
    typedef struct packed {
        logic [3:0]  channel;
        logic [31:0] tot;
        logic [31:0] ts;
    } tdc_event_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } tdc_state_e;

endpackage : tdc_pkg
`default_nettype wire

// File: rtl/tdc_event_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tdc_event_fifo
// Description : Single-clock, show-ahead FIFO of TDC event words.
//               The head word is always presented on rd_data while valid=1.
//               A write into a full FIFO is dropped (drop pulses) unless a
//               pop happens on the same edge, in which case both succeed.
// Ports       : clk, reset (sync, active-high)
//               wr_en, wr_data         - write side
//               rd_ready               - consumer accept (pop when valid)
//               rd_data, valid         - head word and its qualifier
//               full, drop             - occupancy == DEPTH, dropped write
// Revision    : 1.0  initial release
// ============================================================================
module tdc_event_fifo
    import tdc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  tdc_event_t wr_data,
    input  logic       rd_ready,
    output tdc_event_t rd_data,
    output logic       valid,
    output logic       full,
    output logic       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    tdc_event_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign valid   = (r_count != '0);
    assign full    = (r_count == CNT_W'(DEPTH));
    assign rd_data = r_mem[r_rd_ptr];

    // A pop on the same edge frees the slot the write needs, so a full FIFO
    // still accepts the word in that case.
    assign w_pop  = valid & rd_ready;
    assign w_push = wr_en & (~full | w_pop);
    assign drop   = wr_en & full & ~w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; contents are qualified by r_count
    always_ff @(posedge clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule : tdc_event_fifo
`default_nettype wire

// File: rtl/tdc_readout.sv
`default_nettype none
// ============================================================================
// Module      : tdc_readout
// Description : Captures events from a TDC channel, acknowledges each with a
//               one-cycle o_clear pulse and buffers the tagged words in a
//               show-ahead FIFO with valid/ready output handshake.
// Ports       : clk, reset (sync, active-high)
//               i_hasEvent, i_pulseWidth, i_timestamp - TDC event interface
//               o_clear                               - acknowledge to TDC
//               o_valid, i_ready, o_data              - output word stream
//               o_full, o_overflow                    - FIFO status
//               o_dropCount                           - optional, see below
// Config      : define TDC_READOUT_DROP_COUNT_EN to add o_dropCount, a
//               16-bit saturating count of dropped events.
// Revision    : 1.0  initial release
// ============================================================================
module tdc_readout
    import tdc_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CHANNEL_ID = 4'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_hasEvent,
    input  logic [31:0]           i_pulseWidth,
    input  logic [31:0]           i_timestamp,
    output logic                  o_clear,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [TDC_WORD_W-1:0] o_data,
    output logic                  o_full,
    output logic                  o_overflow
`ifdef TDC_READOUT_DROP_COUNT_EN
    ,
    output logic [15:0]           o_dropCount
`endif
);

    localparam logic [1:0] c_ST_IDLE     = ST_IDLE;
    localparam logic [1:0] c_ST_ACK      = ST_ACK;
    localparam logic [1:0] c_ST_WAIT_LOW = ST_WAIT_LOW;

    logic [1:0] r_state;
    tdc_event_t r_event;
    tdc_event_t w_head;
    logic       w_write;
    logic       w_drop;
    logic       r_overflow;

    // --------------------------------------------------------------------
    // Readout FSM: IDLE captures, ACK writes and acknowledges, WAIT_LOW
    // waits for the TDC to drop its flag so one event is captured once.
    // --------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (i_hasEvent) begin
                        r_state <= c_ST_ACK;
                    end
                end
                c_ST_ACK: begin
                    r_state <= c_ST_WAIT_LOW;
                end
                c_ST_WAIT_LOW: begin
                    if (!i_hasEvent) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == c_ST_IDLE && i_hasEvent) begin
            r_event.channel <= CHANNEL_ID;
            r_event.tot     <= i_pulseWidth;
            r_event.ts      <= i_timestamp;
        end
    end

    // The ACK cycle both writes the word and acknowledges the TDC, so the
    // acknowledge is issued even when the FIFO drops the word.
    assign w_write = (r_state == c_ST_ACK);
    assign o_clear = w_write;

    tdc_event_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (w_write),
        .wr_data  (r_event),
        .rd_ready (i_ready),
        .rd_data  (w_head),
        .valid    (o_valid),
        .full     (o_full),
        .drop     (w_drop)
    );

    assign o_data = w_head;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;

`ifdef TDC_READOUT_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop && r_drop_count != 16'hFFFF) begin
            r_drop_count <= r_drop_count + 16'd1;
        end
    end

    assign o_dropCount = r_drop_count;
`endif

endmodule : tdc_readout
`default_nettype wire
